// File: rtl/stream_muxn_pkg.sv
// Shared definitions for the stream_muxn block: parameter defaults,
// mode encoding and a pointer-width helper.
package stream_muxn_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int N_DEF     = 4;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Width needed to hold a channel index 0..n-1 (at least one bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_muxn_rr_arbiter.sv
// Purely combinational round-robin arbiter: grants the first requesting
// channel found searching upward from last_grant+1 with wrap-around.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] last_grant,
  output logic [N-1:0]  grant
);

  int   idx;
  logic found;

  // walk the channels once starting just after the last winner
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_muxn.sv
// N-channel stream multiplexer with a single registered output stage.
// Channel selection is either fixed (by s) or round-robin; the round-robin
// pointer only advances on round-robin transfers.
module stream_muxn
  import stream_muxn_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N     = N_DEF,
  parameter int SELW  = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N-1:0][WIDTH-1:0]   d,
  input  logic [N-1:0]              valid_in,
  output logic [N-1:0]              ready_out,
  input  logic                      mode,
  input  logic [SELW-1:0]           s,
  output logic [WIDTH-1:0]          y,
  output logic                      valid,
  input  logic                      ready
);

  localparam int            PW       = ptr_width(N);
  localparam logic [PW-1:0] LAST_RST = PW'(N - 1);

  logic [PW-1:0] last_grant;
  logic [PW-1:0] grant_idx;
  logic [N-1:0]  rr_grant;
  logic [N-1:0]  fixed_grant;
  logic [N-1:0]  grant;
  logic          free;
  logic          xfer;

  rr_arbiter #(
    .N  (N),
    .PW (PW)
  ) u_rr_arbiter (
    .req        (valid_in),
    .last_grant (last_grant),
    .grant      (rr_grant)
  );

  // fixed select: channel s if it exists and is requesting; s >= N matches nothing
  always_comb begin
    fixed_grant = '0;
    for (int i = 0; i < N; i++) begin
      if (s == SELW'(i)) fixed_grant[i] = valid_in[i];
    end
  end

  // register is free when empty or being drained this cycle
  assign free      = ~valid | ready;
  assign grant     = (mode == MODE_RR) ? rr_grant : fixed_grant;
  assign ready_out = (free && !reset) ? grant : '0;
  assign xfer      = |ready_out;

  // binary index of the granted channel
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = PW'(i);
    end
  end

  // output register and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y          <= '0;
      valid      <= 1'b0;
      last_grant <= LAST_RST;
    end else if (xfer) begin
      y     <= d[grant_idx];
      valid <= 1'b1;
      if (mode == MODE_RR) last_grant <= grant_idx;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_muxn.sv
// Self-checking bench for stream_muxn: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a
// behavioural model of the channel-selection rules.
module tb_stream_muxn;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = 3;
  localparam int N2 = 6;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [N-1:0][W-1:0] d = '0;
  logic [N-1:0]        vin = '0;
  logic [N-1:0]        ready_out;
  logic                mode = 1'b0;
  logic [SW-1:0]       s = '0;
  logic [W-1:0]        y;
  logic                valid;
  logic                ready = 1'b0;

  logic [N2-1:0][W-1:0] d2 = '0;
  logic [N2-1:0]        vin2 = '0;
  logic [N2-1:0]        ready_out2;
  logic [2:0]           s2 = 3'd5;
  logic [W-1:0]         y2;
  logic                 valid2;

  int total  = 0;
  int passed = 0;

  // behavioural model state
  logic         m_valid = 1'b0;
  logic [W-1:0] m_y     = '0;
  int           m_last  = N - 1;

  always #5 clk = ~clk;

  stream_muxn #(.WIDTH(W), .N(N), .SELW(SW)) dut (
    .clk(clk), .reset(rst), .d(d), .valid_in(vin), .ready_out(ready_out),
    .mode(mode), .s(s), .y(y), .valid(valid), .ready(ready)
  );

  stream_muxn #(.WIDTH(W), .N(N2)) dut6 (
    .clk(clk), .reset(rst), .d(d2), .valid_in(vin2), .ready_out(ready_out2),
    .mode(1'b0), .s(s2), .y(y2), .valid(valid2), .ready(1'b1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // channel that wins arbitration under the stated rules, -1 for none
  function automatic int pick(input logic m, input int sel, input logic [N-1:0] v, input int last);
    if (m == 1'b0) begin
      if (sel < N && v[sel]) return sel;
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // model update
  always @(posedge clk or posedge rst) begin
    int g;
    if (rst) begin
      m_valid = 1'b0;
      m_y     = '0;
      m_last  = N - 1;
    end else begin
      g = pick(mode, int'(s), vin, m_last);
      if ((!m_valid || ready) && g >= 0) begin
        m_y     = d[g];
        m_valid = 1'b1;
        if (mode) m_last = g;
      end else if (ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    if (rst) begin
      chk("ready_out_in_reset", ready_out, 0);
    end else begin
      g  = pick(mode, int'(s), vin, m_last);
      er = ((!m_valid || ready) && g >= 0) ? N'(1 << g) : '0;
      chk("ready_out", ready_out, er);
      chk("valid", valid, m_valid);
      chk("y", y, m_y);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] exp_ro;
    int seq[3];
    // DUT with 6 channels: fixed select of channel 5, always requesting
    for (int i = 0; i < N2; i++) d2[i] = 8'h50 + W'(i) + 8'h07;
    vin2 = 6'b100000;

    #1 rst = 1'b1;
    #1;
    chk("reset_y", y, 0);
    chk("reset_valid", valid, 0);
    chk("reset_ready_out", ready_out, 0);
    tick();
    tick();

    // fixed select of channel 2
    rst  = 1'b0;
    mode = 1'b0; s = 3'd2; vin = 4'b0100; ready = 1'b1;
    d[2] = 8'hA5;
    #1 chk("fixed_ready_out", ready_out, 4'b0100);
    tick();
    chk("fixed_y", y, 8'hA5);
    chk("fixed_valid", valid, 1);
    chk("fixed_model_y", m_y, 8'hA5);

    // round-robin with all channels requesting
    for (int i = 0; i < N; i++) d[i] = 8'h10 + W'(i);
    mode = 1'b1; vin = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_ro = N'(1 << (k % 4));
      #1 chk("rr_all_ready_out", ready_out, exp_ro);
      tick();
      chk("rr_all_y", y, 8'h10 + W'(k % 4));
      chk("rr_all_model_y", m_y, 8'h10 + W'(k % 4));
      chk("rr_all_valid", valid, 1);
    end

    // round-robin with gaps: last winner 3 -> 1, 3, 1
    vin = 4'b1010;
    seq = '{1, 3, 1};
    for (int k = 0; k < 3; k++) begin
      exp_ro = N'(1 << seq[k]);
      #1 chk("rr_gap_ready_out", ready_out, exp_ro);
      tick();
      chk("rr_gap_y", y, 8'h10 + W'(seq[k]));
    end

    // backpressure: hold for 5 cycles, then drain and accept together
    ready = 1'b0; vin = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk("stall_ready_out", ready_out, 0);
      tick();
      chk("stall_y", y, 8'h11);
      chk("stall_valid", valid, 1);
    end
    ready = 1'b1;
    #1 chk("release_ready_out", ready_out, 4'b0100);
    tick();
    chk("release_y", y, 8'h12);

    // out-of-range select on 4 channels; channel 5 on 6 channels
    mode = 1'b0; s = 3'd5;
    #1 chk("sel5_n4_ready_out", ready_out, 0);
    chk("sel5_n6_ready_out", ready_out2, 6'b100000);
    chk("sel5_n6_y", y2, 8'h5C);
    tick();
    chk("sel5_n4_valid", valid, 0);
    chk("sel5_n4_y_hold", y, 8'h12);

    // asynchronous reset between edges with a word held
    mode = 1'b1; vin = 4'b1111;
    tick();
    chk("pre_reset_valid", valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_valid", valid, 0);
    chk("async_reset_y", y, 0);
    chk("async_reset_ready_out", ready_out, 0);
    tick();
    rst = 1'b0;
    #1 chk("post_reset_ready_out", ready_out, 4'b0001);
    tick();
    chk("post_reset_y", y, 8'h10);

    // randomized traffic, compared every cycle against the model
    for (int k = 0; k < 600; k++) begin
      tick();
      rst   = ($urandom_range(0, 99) == 0);
      mode  = 1'($urandom_range(0, 1));
      s     = SW'($urandom_range(0, 7));
      vin   = N'($urandom);
      ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) d[i] = W'($urandom);
    end
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
